pic_inta_sequencer: RTL and testbench
=====================================

# pic_inta_sequencer

Interrupt-acknowledge sequencer for the 8259A-compatible interrupt controller. It takes the one-hot resolved request from the priority resolver and raises INT to the CPU. It runs the two-pulse 8086-mode INTA handshake, owns the in-service register (ISR), pulses IRR clears, and drives the vector byte onto the data bus. It also retires ISR bits on EOI commands from the control logic.

## Interface
- `INTA_PULSES`, default 2 — INTA pulses per acknowledge; legal values 1 or 2. With 1, the vector is driven on the first pulse.
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `interrupt`  in  8  one-hot resolved request from the priority resolver; all-zero means no request
- `inta_n`  in  1  CPU acknowledge strobe, active low, already synchronous to `clk`
- `vector_base`  in  5  ICW2 T7..T3
- `eoi_valid`  in  1  one-cycle EOI command strobe
- `eoi_specific`  in  1  1 = specific EOI, 0 = non-specific
- `eoi_level`  in  3  IR level for a specific EOI
- `int_out`  out  1  interrupt request to the CPU
- `clear_irr`  out  8  one-cycle pulse clearing the acknowledged IRR bit
- `in_service_register`  out  8  ISR
- `highest_level_in_service`  out  8  one-hot lowest-index set ISR bit; 0 when ISR is empty
- `data_out`  out  8  vector byte
- `data_oe`  out  1  data bus drive enable

## Operation
- INTA edges: `inta_n` is registered into `inta_q`. Fall = `inta_q & ~inta_n`; rise = `~inta_q & inta_n`. `inta_q` resets to 1.
- FSM states: IDLE, REQ, ACK1, WAIT2, VEC.
- IDLE:
  - `interrupt != 0` -> REQ, `int_out` = 1.
  - A fall in IDLE is ignored.
- REQ, on fall:
  - Capture level L = index of `interrupt`. If `interrupt == 0`, the acknowledge is spurious: L = 7, no ISR set, no `clear_irr`.
  - Otherwise set ISR[L] and pulse `clear_irr[L]` for one cycle.
  - `int_out` = 0. Go to ACK1; with `INTA_PULSES == 1`, go to VEC instead.
- ACK1: `data_oe` = 0. On rise -> WAIT2.
- WAIT2: on fall -> VEC.
- VEC:
  - `data_out = {vector_base, L}`, `data_oe` = 1 while in VEC.
  - On rise -> IDLE; `data_oe` and `data_out` return to 0.
- `interrupt` changes after capture have no effect until IDLE.
- EOI (`eoi_valid`):
  - Non-specific: clear the ISR bit given by `highest_level_in_service`; no-op if ISR is empty.
  - Specific: clear ISR[`eoi_level`].
- Simultaneous EOI and ISR set: EOI is evaluated on the old ISR, then the set is applied. If both target the same bit, the set wins.
- Nested acknowledges: ISR may hold several bits; the FSM handles one acknowledge at a time.
- Reset (including mid-handshake): FSM to IDLE; ISR, `clear_irr`, `int_out`, `data_out`, `data_oe` = 0; `inta_q` = 1.

## Timing
- All outputs are registered.
- `int_out` rises 1 cycle after `interrupt` goes nonzero in IDLE.
- ISR bit, `clear_irr` pulse and `int_out` fall appear 1 cycle after the cycle where `inta_n` is first sampled 0 in REQ.
- `data_oe` rises 1 cycle after the second fall. It drops 1 cycle after `inta_n` is sampled 1.
- EOI takes effect on ISR 1 cycle after `eoi_valid`.
- `highest_level_in_service` is combinational from the registered ISR.
- Minimum INTA low or high phase: 2 cycles.

## Configuration
- `PIC_AUTO_EOI_EN` defined: adds input `aeoi` (1 bit, ICW4 AEOI).
  - When `aeoi` = 1, ISR[L] is cleared on the VEC -> IDLE transition, in the same cycle `data_oe` drops.
  - The `aeoi` port exists only when the macro is defined.
- `PIC_AUTO_EOI_EN` undefined: no `aeoi` port; ISR bits clear only on EOI.

## Test plan
- `vector_base` = 5'h08, `interrupt` = 8'h04, two INTA pulses -> `int_out` rises; `clear_irr` = 8'h04 for 1 cycle; ISR = 8'h04; `data_out` = 8'h42 with `data_oe` = 1 on the second pulse only.
- `interrupt` returns to 0 before the first INTA fall -> spurious acknowledge: ISR unchanged, `clear_irr` = 0, vector = 8'h47.
- ISR = 8'h0A: non-specific EOI -> ISR = 8'h08; then specific EOI level 3 -> ISR = 8'h00; non-specific EOI on empty ISR -> no change.
- Specific EOI level 2 in the same cycle as an ISR set of level 2 -> ISR[2] = 1.
- Reset asserted during WAIT2 -> next cycle: all outputs 0, FSM in IDLE; a later fall without a request is ignored.
- With `PIC_AUTO_EOI_EN` and `aeoi` = 1, IR5 acknowledge -> ISR[5] = 1 during the handshake and 0 the cycle after the second `inta_n` rise is sampled.

Source files
------------

// File: rtl/pic_inta_sequencer.sv
// 8259A-style interrupt-acknowledge sequencer: INT/INTA handshake, ISR ownership, EOI retirement.
// Optional PIC_AUTO_EOI_EN adds an aeoi input that retires ISR[L] at the end of the vector pulse.
module pic_inta_sequencer #(
   parameter int INTA_PULSES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] interrupt,
   input  logic       inta_n,
   input  logic [4:0] vector_base,
   input  logic       eoi_valid,
   input  logic       eoi_specific,
   input  logic [2:0] eoi_level,
`ifdef PIC_AUTO_EOI_EN
   input  logic       aeoi,
`endif
   output logic       int_out,
   output logic [7:0] clear_irr,
   output logic [7:0] in_service_register,
   output logic [7:0] highest_level_in_service,
   output logic [7:0] data_out,
   output logic       data_oe
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] REQ   = 3'd1;
   localparam logic [2:0] ACK1  = 3'd2;
   localparam logic [2:0] WAIT2 = 3'd3;
   localparam logic [2:0] VEC   = 3'd4;

   logic [2:0] state_q, state_d;
   logic       inta_q;
   logic [2:0] level_q, level_d;
   logic [7:0] isr_q, isr_d;
   logic [7:0] clear_irr_q, clear_irr_d;
   logic       int_out_q, int_out_d;
   logic [7:0] data_out_q, data_out_d;
   logic       data_oe_q, data_oe_d;
`ifdef PIC_AUTO_EOI_EN
   logic       spurious_q, spurious_d;
`endif

   logic       inta_fall, inta_rise;
   logic [7:0] set_mask, eoi_mask, aeoi_mask;

   function automatic logic [2:0] encode(input logic [7:0] onehot);
      encode = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (onehot[i]) encode = 3'(i);
      end
   endfunction

   assign inta_fall = inta_q & ~inta_n;
   assign inta_rise = ~inta_q & inta_n;

   // Isolate the lowest-index set bit: highest priority under fixed ordering.
   assign highest_level_in_service = isr_q & (~isr_q + 8'd1);

   always_comb begin
      // NOTE: every _d starts from a default so no path leaves it unassigned (no latch).
      state_d     = state_q;
      level_d     = level_q;
      clear_irr_d = 8'h00;
      int_out_d   = int_out_q;
      data_out_d  = data_out_q;
      data_oe_d   = data_oe_q;
      set_mask    = 8'h00;
      aeoi_mask   = 8'h00;
`ifdef PIC_AUTO_EOI_EN
      spurious_d  = spurious_q;
`endif

      eoi_mask = 8'h00;
      if (eoi_valid) begin
         eoi_mask = eoi_specific ? (8'b1 << eoi_level) : highest_level_in_service;
      end

      case (state_q)
         IDLE: begin
            if (|interrupt) begin
               state_d   = REQ;
               int_out_d = 1'b1;
            end
         end
         REQ: begin
            if (inta_fall) begin
               int_out_d = 1'b0;
               if (|interrupt) begin
                  level_d     = encode(interrupt);
                  set_mask    = 8'b1 << level_d;
                  clear_irr_d = set_mask;
               end else begin
                  level_d = 3'd7;
               end
`ifdef PIC_AUTO_EOI_EN
               spurious_d = ~|interrupt;
`endif
               if (INTA_PULSES == 1) begin
                  state_d    = VEC;
                  data_out_d = {vector_base, level_d};
                  data_oe_d  = 1'b1;
               end else begin
                  state_d = ACK1;
               end
            end
         end
         ACK1: begin
            data_oe_d = 1'b0;
            if (inta_rise) state_d = WAIT2;
         end
         WAIT2: begin
            if (inta_fall) begin
               state_d    = VEC;
               data_out_d = {vector_base, level_q};
               data_oe_d  = 1'b1;
            end
         end
         VEC: begin
            if (inta_rise) begin
               state_d    = IDLE;
               data_out_d = 8'h00;
               data_oe_d  = 1'b0;
`ifdef PIC_AUTO_EOI_EN
               if (aeoi && !spurious_q) aeoi_mask = 8'b1 << level_q;
`endif
            end
         end
         default: state_d = IDLE;
      endcase

      // EOI is judged against the old ISR; a same-cycle set of the same bit survives.
      isr_d = (isr_q & ~eoi_mask & ~aeoi_mask) | set_mask;
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         state_q     <= IDLE;
         inta_q      <= 1'b1;
         level_q     <= 3'd0;
         isr_q       <= 8'h00;
         clear_irr_q <= 8'h00;
         int_out_q   <= 1'b0;
         data_out_q  <= 8'h00;
         data_oe_q   <= 1'b0;
`ifdef PIC_AUTO_EOI_EN
         spurious_q  <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         inta_q      <= inta_n;
         level_q     <= level_d;
         isr_q       <= isr_d;
         clear_irr_q <= clear_irr_d;
         int_out_q   <= int_out_d;
         data_out_q  <= data_out_d;
         data_oe_q   <= data_oe_d;
`ifdef PIC_AUTO_EOI_EN
         spurious_q  <= spurious_d;
`endif
      end
   end

   assign int_out             = int_out_q;
   assign clear_irr           = clear_irr_q;
   assign in_service_register = isr_q;
   assign data_out            = data_out_q;
   assign data_oe             = data_oe_q;

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Scoreboard bench for pic_inta_sequencer: stimulus pushes expected output snapshots,
// a monitor pops one on every observed output change and checks value and cycle.
module tb_pic_inta_sequencer;

   typedef struct packed {
      logic       int_out;
      logic [7:0] clear_irr;
      logic [7:0] isr;
      logic [7:0] hlis;
      logic [7:0] data_out;
      logic       data_oe;
   } snap_t;

   typedef struct packed {
      int   cyc;
      snap_t s;
   } rec_t;

   logic       clk;
   logic       reset;
   logic [7:0] interrupt;
   logic       inta_n;
   logic [4:0] vector_base;
   logic       eoi_valid;
   logic       eoi_specific;
   logic [2:0] eoi_level;
`ifdef PIC_AUTO_EOI_EN
   logic       aeoi;
`endif
   logic       int_out;
   logic [7:0] clear_irr;
   logic [7:0] isr;
   logic [7:0] hlis;
   logic [7:0] data_out;
   logic       data_oe;

   rec_t  exp_q[$];
   string tag_q[$];
   snap_t exp_s;
   snap_t last_s;
   int    vectors     = 0;
   int    miscompares = 0;
   int    cyc         = 0;
   bit    mon_en      = 0;

   pic_inta_sequencer dut (
      .clk                      (clk),
      .reset                    (reset),
      .interrupt                (interrupt),
      .inta_n                   (inta_n),
      .vector_base              (vector_base),
      .eoi_valid                (eoi_valid),
      .eoi_specific             (eoi_specific),
      .eoi_level                (eoi_level),
`ifdef PIC_AUTO_EOI_EN
      .aeoi                     (aeoi),
`endif
      .int_out                  (int_out),
      .clear_irr                (clear_irr),
      .in_service_register      (isr),
      .highest_level_in_service (hlis),
      .data_out                 (data_out),
      .data_oe                  (data_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] lowest(input logic [7:0] v);
      for (int i = 0; i < 8; i++) begin
         if (v[i]) return 8'(1 << i);
      end
      return 8'h00;
   endfunction

   task automatic check(input string name, input rec_t got, input rec_t want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got cyc=%0d int=%b clr=%h isr=%h hlis=%h dout=%h oe=%b, required cyc=%0d int=%b clr=%h isr=%h hlis=%h dout=%h oe=%b",
                  name, got.cyc, got.s.int_out, got.s.clear_irr, got.s.isr, got.s.hlis,
                  got.s.data_out, got.s.data_oe, want.cyc, want.s.int_out, want.s.clear_irr,
                  want.s.isr, want.s.hlis, want.s.data_out, want.s.data_oe);
      end
   endtask

   // Monitor: every change of the output bundle must match the next queued expectation.
   initial begin
      snap_t prev_s;
      snap_t cur_s;
      rec_t  got;
      rec_t  want;
      string tag;
      prev_s = 'x;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            cur_s = {int_out, clear_irr, isr, hlis, data_out, data_oe};
            if (cur_s !== prev_s) begin
               got.cyc = cyc;
               got.s   = cur_s;
               if (exp_q.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL unexpected_change: cyc=%0d int=%b clr=%h isr=%h dout=%h oe=%b, required no change",
                           cyc, cur_s.int_out, cur_s.clear_irr, cur_s.isr, cur_s.data_out, cur_s.data_oe);
               end else begin
                  want = exp_q.pop_front();
                  tag  = tag_q.pop_front();
                  check(tag, got, want);
               end
            end
            prev_s = cur_s;
         end
      end
   end

   // Advance one cycle; queue the expected post-edge outputs if they differ from before.
   task automatic step(input string tag);
      rec_t r;
      exp_s.hlis = lowest(exp_s.isr);
      if (exp_s !== last_s) begin
         r.cyc = cyc + 1;
         r.s   = exp_s;
         exp_q.push_back(r);
         tag_q.push_back(tag);
         last_s = exp_s;
      end
      @(negedge clk);
   endtask

   task automatic ack(input logic [7:0] req, input bit drop, input logic [7:0] isr_set,
                      input logic [7:0] vec, input logic [7:0] isr_done,
                      input bit eoi_en = 1'b0, input bit eoi_spec = 1'b0,
                      input logic [2:0] eoi_lvl = 3'd0);
      interrupt = req;
      exp_s.int_out = 1'b1;
      step("int_rise");
      if (drop) begin
         interrupt = 8'h00;
         step("req_drop");
      end
      inta_n       = 1'b0;
      eoi_valid    = eoi_en;
      eoi_specific = eoi_spec;
      eoi_level    = eoi_lvl;
      exp_s.int_out   = 1'b0;
      exp_s.isr       = isr_set;
      exp_s.clear_irr = drop ? 8'h00 : req;
      step("first_fall");
      eoi_valid = 1'b0;
      interrupt = 8'h00;
      exp_s.clear_irr = 8'h00;
      step("clear_pulse_end");
      inta_n = 1'b1;
      step("first_rise");
      step("first_high");
      inta_n = 1'b0;
      exp_s.data_out = vec;
      exp_s.data_oe  = 1'b1;
      step("vector_drive");
      step("vector_hold");
      inta_n = 1'b1;
      exp_s.data_out = 8'h00;
      exp_s.data_oe  = 1'b0;
      exp_s.isr      = isr_done;
      step("vector_release");
      step("back_idle");
   endtask

   task automatic eoi(input bit spec, input logic [2:0] lvl, input logic [7:0] isr_after);
      eoi_valid    = 1'b1;
      eoi_specific = spec;
      eoi_level    = lvl;
      exp_s.isr    = isr_after;
      step(spec ? "specific_eoi" : "nonspecific_eoi");
      eoi_valid = 1'b0;
      step("eoi_idle");
   endtask

   initial begin
      reset        = 1'b1;
      interrupt    = 8'h00;
      inta_n       = 1'b1;
      vector_base  = 5'h08;
      eoi_valid    = 1'b0;
      eoi_specific = 1'b0;
      eoi_level    = 3'd0;
`ifdef PIC_AUTO_EOI_EN
      aeoi         = 1'b0;
`endif
      exp_s  = '0;
      last_s = 'x;
      mon_en = 1'b1;
      step("reset_state");
      step("reset_hold");
      reset = 1'b0;
      step("reset_release");

      // Basic IR2 acknowledge: vector 0x42 on the second pulse only.
      ack(8'h04, 1'b0, 8'h04, 8'h42, 8'h04);
      // Request withdrawn before the first fall: spurious, vector 0x47.
      ack(8'h10, 1'b1, 8'h04, 8'h47, 8'h04);
      // Nest IR1 and IR3 on top of IR2.
      ack(8'h02, 1'b0, 8'h06, 8'h41, 8'h06);
      ack(8'h08, 1'b0, 8'h0E, 8'h43, 8'h0E);

      eoi(1'b1, 3'd2, 8'h0A);
      eoi(1'b0, 3'd0, 8'h08);
      eoi(1'b1, 3'd3, 8'h00);
      eoi(1'b0, 3'd5, 8'h00);

      // Specific EOI of level 2 while level 2 is being set: the set survives.
      ack(8'h04, 1'b0, 8'h04, 8'h42, 8'h04, 1'b1, 1'b1, 3'd2);
      ack(8'h08, 1'b0, 8'h0C, 8'h43, 8'h0C);
      // Non-specific EOI while IR1 is being set retires IR2 (old highest), not IR1.
      ack(8'h02, 1'b0, 8'h0A, 8'h41, 8'h0A, 1'b1, 1'b0, 3'd0);

      // Reset during WAIT2.
      interrupt = 8'h20;
      exp_s.int_out = 1'b1;
      step("int_rise_ir5");
      inta_n = 1'b0;
      exp_s.int_out   = 1'b0;
      exp_s.isr       = 8'h2A;
      exp_s.clear_irr = 8'h20;
      step("first_fall_ir5");
      interrupt = 8'h00;
      exp_s.clear_irr = 8'h00;
      step("clear_pulse_end_ir5");
      inta_n = 1'b1;
      step("first_rise_ir5");
      step("wait2");
      reset = 1'b1;
      exp_s = '0;
      step("mid_handshake_reset");
      reset = 1'b0;
      step("post_reset");
      inta_n = 1'b0;
      step("idle_fall_ignored");
      step("idle_low");
      inta_n = 1'b1;
      step("idle_rise");
      step("idle_high");
      ack(8'h01, 1'b0, 8'h01, 8'h40, 8'h01);

`ifdef PIC_AUTO_EOI_EN
      aeoi = 1'b1;
      ack(8'h20, 1'b0, 8'h21, 8'h45, 8'h01);
      aeoi = 1'b0;
`endif

      step("drain0");
      step("drain1");
      step("drain2");
      mon_en = 1'b0;

      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: %0d expectations left unmatched, required 0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
